// File: rtl/pcie_rd_req_splitter_if.sv
// Request, chunk, tag-return and status signals of the read request splitter.
// The slave modport is the splitter's view; master is the view of the surrounding logic.
interface pcie_rd_req_splitter_if #(
  parameter int MAX_RD_REQ_BYTES = 512,
  parameter int NUM_TAGS         = 128,
  parameter int ADDR_W           = 64,
  parameter int LEN_DW_W         = 14
);
  localparam int MRRS_DW = MAX_RD_REQ_BYTES / 4;
  localparam int TAG_W   = $clog2(NUM_TAGS);
  localparam int OLEN_W  = $clog2(MRRS_DW) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic [LEN_DW_W-1:0] in_len_dw;

  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_addr;
  logic [OLEN_W-1:0]   out_len_dw;
  logic [TAG_W-1:0]    out_tag;
  logic                out_last;

  logic                free_valid;
  logic [TAG_W-1:0]    free_tag;

  logic [TAG_W:0]      tags_in_use;
  logic                err_double_free;

  modport slave (
    input  in_valid, in_addr, in_len_dw, out_ready, free_valid, free_tag,
    output in_ready, out_valid, out_addr, out_len_dw, out_tag, out_last,
           tags_in_use, err_double_free
  );

  modport master (
    output in_valid, in_addr, in_len_dw, out_ready, free_valid, free_tag,
    input  in_ready, out_valid, out_addr, out_len_dw, out_tag, out_last,
           tags_in_use, err_double_free
  );
endinterface

// File: rtl/pcie_rd_req_splitter.sv
// Splits host read requests into MRRS-bounded, boundary-aligned chunks and tags
// each chunk from a busy-bitmap tag pool that the completion tracker refills.
module pcie_rd_req_splitter #(
  parameter int MAX_RD_REQ_BYTES = 512,
  parameter int NUM_TAGS         = 128,
  parameter int ADDR_W           = 64,
  parameter int LEN_DW_W         = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_rd_req_splitter_if.slave  bus
);
  localparam int MRRS_DW = MAX_RD_REQ_BYTES / 4;
  localparam int TAG_W   = $clog2(NUM_TAGS);
  localparam int OLEN_W  = $clog2(MRRS_DW) + 1;
  localparam int OFF_W   = $clog2(MAX_RD_REQ_BYTES);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_DW_W-1:0] r_rem;
  logic [NUM_TAGS-1:0] r_busy;
  logic [NUM_TAGS-1:0] w_busy_nxt;
  logic [TAG_W:0]      r_tags_in_use;
  logic                r_err;
  logic                r_hold_vld;
  logic [TAG_W-1:0]    r_hold_tag;

  logic                w_any_free;
  logic [TAG_W-1:0]    w_low_tag;
  logic [OLEN_W-1:0]   w_room;
  logic [OLEN_W-1:0]   w_chunk;
  logic                w_last;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_out_valid;
  logic [TAG_W-1:0]    w_out_tag;
  logic                w_fire;
  logic                w_free_ok;

  assign w_any_free = ~&r_busy;

  always_comb begin
    w_low_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_low_tag = TAG_W'(i);
    end
  end

  // Room left before the next MRRS-aligned boundary bounds every chunk.
  assign w_room  = OLEN_W'(MRRS_DW) - {1'b0, r_cur_addr[OFF_W-1:2]};
  assign w_chunk = (r_rem < LEN_DW_W'(w_room)) ? OLEN_W'(r_rem) : w_room;
  assign w_last  = (r_rem == LEN_DW_W'(w_chunk));

  assign w_in_ready  = (r_state == IDLE) && !rst;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_out_valid = (r_state == SPLIT) && (r_hold_vld || w_any_free);
  assign w_out_tag   = r_hold_vld ? r_hold_tag : w_low_tag;
  assign w_fire      = w_out_valid && bus.out_ready;
  assign w_free_ok   = bus.free_valid && r_busy[bus.free_tag];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && (bus.in_len_dw != '0)) w_state_nxt = SPLIT;
      SPLIT:   if (w_fire && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_free_ok) w_busy_nxt[bus.free_tag] = 1'b0;
    if (w_fire)    w_busy_nxt[w_out_tag]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr    <= '0;
      r_rem         <= '0;
      r_busy        <= '0;
      r_tags_in_use <= '0;
      r_err         <= 1'b0;
      r_hold_vld    <= 1'b0;
      r_hold_tag    <= '0;
    end else begin
      r_err  <= bus.free_valid && !r_busy[bus.free_tag];
      r_busy <= w_busy_nxt;

      if (w_accept && (bus.in_len_dw != '0)) begin
        r_cur_addr <= bus.in_addr & ~ADDR_W'(3);
        r_rem      <= bus.in_len_dw;
      end else if (w_fire) begin
        r_cur_addr <= r_cur_addr + ADDR_W'({w_chunk, 2'b00});
        r_rem      <= r_rem - LEN_DW_W'(w_chunk);
      end

      // A stalled chunk keeps its tag even if a lower tag is returned meanwhile.
      if (w_fire) begin
        r_hold_vld <= 1'b0;
      end else if (w_out_valid) begin
        r_hold_vld <= 1'b1;
        r_hold_tag <= w_out_tag;
      end

      case ({w_fire, w_free_ok})
        2'b10:   r_tags_in_use <= r_tags_in_use + 1'b1;
        2'b01:   r_tags_in_use <= r_tags_in_use - 1'b1;
        default: r_tags_in_use <= r_tags_in_use;
      endcase
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_addr        = r_cur_addr;
  assign bus.out_len_dw      = w_chunk;
  assign bus.out_tag         = w_out_tag;
  assign bus.out_last        = (r_state == SPLIT) && w_last;
  assign bus.tags_in_use     = r_tags_in_use;
  assign bus.err_double_free = r_err;
endmodule

// File: tb/tb_pcie_rd_req_splitter.sv
// Directed bench for pcie_rd_req_splitter: inputs change and outputs are checked
// on the falling clock edge, with expected values worked out by hand.
module tb_pcie_rd_req_splitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  pcie_rd_req_splitter_if #(.MAX_RD_REQ_BYTES(512), .NUM_TAGS(128), .ADDR_W(64), .LEN_DW_W(14)) bus ();

  pcie_rd_req_splitter #(.MAX_RD_REQ_BYTES(512), .NUM_TAGS(128), .ADDR_W(64), .LEN_DW_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input logic [13:0] len);
    bus.in_valid  = 1'b1;
    bus.in_addr   = addr;
    bus.in_len_dw = len;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic checkChunk(input string name, input logic [63:0] addr, input logic [63:0] len,
                            input logic [63:0] tag, input logic [63:0] last);
    checkOutput({name, "_valid"}, bus.out_valid, 1);
    checkOutput({name, "_addr"},  bus.out_addr,  addr);
    checkOutput({name, "_len"},   bus.out_len_dw, len);
    checkOutput({name, "_tag"},   bus.out_tag,   tag);
    checkOutput({name, "_last"},  bus.out_last,  last);
  endtask

  task automatic freeTag(input logic [6:0] tag);
    bus.free_valid = 1'b1;
    bus.free_tag   = tag;
    tick();
    bus.free_valid = 1'b0;
  endtask

  task automatic runHandshakes(input string name, input int target, input int budget);
    int count = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (count == target) break;
      if (bus.out_valid) count++;
      tick();
    end
    bus.out_ready = 1'b0;
    checkOutput(name, count, target);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.in_len_dw  = '0;
    bus.out_ready  = 1'b0;
    bus.free_valid = 1'b0;
    bus.free_tag   = '0;

    tick();
    tick();
    checkOutput("rst_in_ready",  bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_last",  bus.out_last, 0);
    checkOutput("rst_in_use",    bus.tags_in_use, 0);
    checkOutput("rst_err",       bus.err_double_free, 0);
    rst = 1'b0;
    tick();

    // 256 DW from an aligned address: two full 128 DW chunks.
    checkOutput("t1_in_ready_idle", bus.in_ready, 1);
    applyStimulus(64'h1000, 14'd256);
    checkOutput("t1_in_ready_busy", bus.in_ready, 0);
    checkChunk("t1_c0", 64'h1000, 128, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    checkChunk("t1_c1", 64'h1200, 128, 1, 1);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t1_done_valid", bus.out_valid, 0);
    checkOutput("t1_in_ready_after", bus.in_ready, 1);
    checkOutput("t1_in_use", bus.tags_in_use, 2);
    freeTag(0);
    freeTag(1);
    checkOutput("t1_in_use_freed", bus.tags_in_use, 0);
    checkOutput("t1_err_none", bus.err_double_free, 0);

    // Unaligned start: 4 DW up to the 512 B boundary, then the remaining 60.
    applyStimulus(64'h11F0, 14'd64);
    checkChunk("t2_c0", 64'h11F0, 4, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    checkChunk("t2_c1", 64'h1200, 60, 1, 1);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t2_in_use", bus.tags_in_use, 2);
    freeTag(0);
    freeTag(1);

    // Exhaustion: 100 chunks then 28 of a 40-chunk request use all 128 tags.
    applyStimulus(64'h0, 14'd12800);
    runHandshakes("t3_req1_chunks", 100, 200);
    checkOutput("t3_req1_idle", bus.in_ready, 1);
    applyStimulus(64'h100000, 14'd5120);
    runHandshakes("t3_req2_chunks", 28, 100);
    checkOutput("t3_empty_valid", bus.out_valid, 0);
    checkOutput("t3_empty_in_use", bus.tags_in_use, 128);
    freeTag(5);
    checkChunk("t3_refill", 64'h103800, 128, 5, 0);
    checkOutput("t3_refill_in_use", bus.tags_in_use, 127);

    // Backpressure with tag 0 returned mid-stall: the chunk keeps tag 5.
    tick();
    checkChunk("t4_stall1", 64'h103800, 128, 5, 0);
    freeTag(0);
    checkChunk("t4_stall2", 64'h103800, 128, 5, 0);
    checkOutput("t4_in_use_stall", bus.tags_in_use, 126);
    tick();
    checkChunk("t4_stall3", 64'h103800, 128, 5, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkChunk("t4_next", 64'h103A00, 128, 0, 0);
    checkOutput("t4_in_use_after", bus.tags_in_use, 127);

    // Reset from a saturated pool.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_rst_valid", bus.out_valid, 0);
    checkOutput("t5_rst_in_use", bus.tags_in_use, 0);
    tick();

    // Double free of unallocated tag 7, then a zero-length request.
    freeTag(7);
    checkOutput("t6_err_pulse", bus.err_double_free, 1);
    checkOutput("t6_in_use", bus.tags_in_use, 0);
    tick();
    checkOutput("t6_err_clear", bus.err_double_free, 0);
    checkOutput("t6_zero_ready", bus.in_ready, 1);
    applyStimulus(64'h4000, 14'd0);
    checkOutput("t6_zero_valid", bus.out_valid, 0);
    checkOutput("t6_zero_ready_after", bus.in_ready, 1);
    tick();
    checkOutput("t6_zero_valid2", bus.out_valid, 0);

    // Reset after one of four chunks, then a fresh request restarts at tag 0.
    applyStimulus(64'h2000, 14'd512);
    checkChunk("t7_c0", 64'h2000, 128, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    checkChunk("t7_c1", 64'h2200, 128, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("t7_rst_valid", bus.out_valid, 0);
    checkOutput("t7_rst_in_use", bus.tags_in_use, 0);
    tick();
    checkOutput("t7_ready", bus.in_ready, 1);
    applyStimulus(64'h3000, 14'd16);
    checkChunk("t7_new", 64'h3000, 16, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
